// File: rtl/lat_return_buffer.sv
// Credit-gated return buffer for a fixed-latency, non-stallable pipeline.
// Define LAT_RETURN_BUFFER_BYPASS_EN for same-cycle return-to-output bypass.
module lat_return_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  output logic                         issue_o,
  output logic [$clog2(DEPTH+1)-1:0]   credits_o,
  input  logic                         ret_valid_i,
  input  logic [DATA_WIDTH-1:0]        ret_data_i,
  output logic                         valid_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cred_q, cred_d;
  logic [CW:0]   cred_sum;
  logic          ovf_q, ovf_d;
  logic          pop, drain, wr_en, byp, byp_take;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign issue_o = req_i && (cred_q != '0) && !rst_i;

`ifdef LAT_RETURN_BUFFER_BYPASS_EN
  assign byp = (cnt_q == '0) && ret_valid_i;
`else
  assign byp = 1'b0;
`endif

  assign valid_o  = (cnt_q != '0) || byp;
  assign data_o   = (cnt_q != '0) ? mem_q[rd_q]
                  : (byp ? ret_data_i : '0);
  assign pop      = valid_o && ready_i;
  // A bypassed return consumed this cycle never touches storage.
  assign byp_take = byp && ready_i;
  assign drain    = pop && !byp;
  assign wr_en    = ret_valid_i && !byp_take
                 && ((cnt_q != FULL) || pop);

  always_comb begin
    rd_d     = drain ? inc(rd_q) : rd_q;
    wr_d     = wr_en ? inc(wr_q) : wr_q;
    cnt_d    = cnt_q + CW'(wr_en) - CW'(drain);
    ovf_d    = ovf_q || (ret_valid_i && !byp_take && !wr_en);
    cred_sum = {1'b0, cred_q} + (CW+1)'(pop)
             - (CW+1)'(issue_o);
    cred_d   = (cred_sum > {1'b0, FULL}) ? FULL
             : cred_sum[CW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      cred_q <= FULL;
      ovf_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      cred_q <= cred_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) mem_q[wr_q] <= ret_data_i;
  end

  assign credits_o  = cred_q;
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule
